flash_erase_seq: RTL and testbench

Sequencer in front of the spictl SPI master that runs a complete, self-contained SPI-flash erase. On a start pulse it issues Write Enable (0x06), then the erase command: chip 0xC7, 4 KB sector 0x20 + addr, or 64 KB block 0xD8 + addr. It then polls Read Status (0x05) until WIP clears or a timeout expires. It drives spictl's trig/datalength/senddata and reads back recvdata, replacing the button-to-trig glue used today.

---
 rtl/flash_erase_seq.sv | 185 ++++++++++++++++++
 tb/tb_flash_erase_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_erase_seq.sv
// flash_erase_seq: drives the spictl SPI master through a full SPI-flash erase.
// Sequence: Write Enable, then the chip/sector/block erase command, then
// Read Status polls spaced POLL_GAP cycles apart until WIP clears or POLL_MAX
// polls have been spent.
module flash_erase_seq #(
    parameter int POLL_GAP = 50000,
    parameter int POLL_MAX = 200000
) (
    input  logic         sclk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [23:0]  addr,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [7:0]   status,
    output logic         spi_trig,
    output logic [7:0]   spi_datalength,
    output logic [127:0] spi_senddata,
    input  logic         spi_ready,
    input  logic [127:0] spi_recvdata
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [31:0] POLL_LIMIT = 32'(POLL_MAX);

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_WREN_ISSUE  = 4'd1;
    localparam logic [3:0] S_WREN_WAIT   = 4'd2;
    localparam logic [3:0] S_ERASE_ISSUE = 4'd3;
    localparam logic [3:0] S_ERASE_WAIT  = 4'd4;
    localparam logic [3:0] S_GAP         = 4'd5;
    localparam logic [3:0] S_POLL_ISSUE  = 4'd6;
    localparam logic [3:0] S_POLL_WAIT   = 4'd7;
    localparam logic [3:0] S_CHECK       = 4'd8;
    localparam logic [3:0] S_DONE        = 4'd9;
    localparam logic [3:0] S_ERR         = 4'd10;

    localparam logic [1:0] OP_CHIP   = 2'd0;
    localparam logic [1:0] OP_SECTOR = 2'd1;
    localparam logic [1:0] OP_BLOCK  = 2'd2;
    localparam logic [1:0] OP_BAD    = 2'd3;

    logic [3:0]       state;
    logic [1:0]       op_q;
    logic [23:0]      addr_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [31:0]      poll_cnt;
    logic             acked;
    logic             issuing;
    logic             unused_recv;

    // Only the last received byte matters; the rest of the shift data is ignored.
    assign unused_recv = ^spi_recvdata[127:8];

    // Trigger spictl only while sitting in an ISSUE state and spictl is idle;
    // the state advances on that same edge, so the pulse lasts one cycle.
    assign issuing  = (state == S_WREN_ISSUE) || (state == S_ERASE_ISSUE) ||
                      (state == S_POLL_ISSUE);
    assign spi_trig = issuing && spi_ready;

    // Main sequencer: walks the command phases and owns every registered output.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            op_q           <= OP_CHIP;
            addr_q         <= 24'h0;
            gap_cnt        <= '0;
            poll_cnt       <= 32'h0;
            acked          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            status         <= 8'h00;
            spi_datalength <= 8'h00;
            spi_senddata   <= 128'h0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        addr_q   <= addr;
                        busy     <= 1'b1;
                        gap_cnt  <= '0;
                        poll_cnt <= 32'h0;
                        if (op == OP_BAD) begin
                            error <= 1'b1;
                            state <= S_ERR;
                        end else begin
                            error          <= 1'b0;
                            spi_datalength <= 8'd8;
                            spi_senddata   <= {120'h0, 8'h06};
                            state          <= S_WREN_ISSUE;
                        end
                    end
                end

                S_WREN_ISSUE, S_ERASE_ISSUE, S_POLL_ISSUE: begin
                    if (spi_ready) begin
                        acked <= 1'b0;
                        state <= state + 4'd1;
                    end
                end

                S_WREN_WAIT, S_ERASE_WAIT, S_POLL_WAIT: begin
                    if (!acked) begin
                        if (!spi_ready) begin
                            acked <= 1'b1;
                        end
                    end else if (spi_ready) begin
                        if (state == S_WREN_WAIT) begin
                            case (op_q)
                                OP_SECTOR: begin
                                    spi_datalength <= 8'd32;
                                    spi_senddata   <= {96'h0, 8'h20, addr_q};
                                end
                                OP_BLOCK: begin
                                    spi_datalength <= 8'd32;
                                    spi_senddata   <= {96'h0, 8'hD8, addr_q};
                                end
                                default: begin
                                    spi_datalength <= 8'd8;
                                    spi_senddata   <= {120'h0, 8'hC7};
                                end
                            endcase
                            state <= S_ERASE_ISSUE;
                        end else if (state == S_ERASE_WAIT) begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else begin
                            status <= spi_recvdata[7:0];
                            if (poll_cnt != 32'hFFFF_FFFF) begin
                                poll_cnt <= poll_cnt + 32'd1;
                            end
                            state <= S_CHECK;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt >= GAP_LAST) begin
                        spi_datalength <= 8'd16;
                        spi_senddata   <= {112'h0, 16'h0500};
                        state          <= S_POLL_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                S_CHECK: begin
                    if (!status[0]) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (poll_cnt >= POLL_LIMIT) begin
                        error <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                S_ERR: begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_erase_seq.sv
// tb_flash_erase_seq: directed bench for flash_erase_seq with a small spictl
// model that records every frame and answers status polls from a queue.
module tb_flash_erase_seq;

    localparam int POLL_GAP = 10;
    localparam int POLL_MAX = 4;

    logic         sclk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [23:0]  addr;
    logic         busy;
    logic         done;
    logic         error;
    logic [7:0]   status;
    logic         spi_trig;
    logic [7:0]   spi_datalength;
    logic [127:0] spi_senddata;
    logic         spi_ready;
    logic [127:0] spi_recvdata;

    logic         model_ready;
    logic         hold_low;
    int           busy_left;
    int           cyc;
    int           trig_cnt;
    int           done_cnt;
    int           frame_cnt;
    logic [7:0]   frame_len  [0:63];
    logic [127:0] frame_data [0:63];
    int           frame_cyc  [0:63];
    logic [7:0]   resp_q [$];

    int n_assert;
    int n_fail;

    flash_erase_seq #(
        .POLL_GAP(POLL_GAP),
        .POLL_MAX(POLL_MAX)
    ) dut (
        .sclk           (sclk),
        .rst            (rst),
        .start          (start),
        .op             (op),
        .addr           (addr),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .status         (status),
        .spi_trig       (spi_trig),
        .spi_datalength (spi_datalength),
        .spi_senddata   (spi_senddata),
        .spi_ready      (spi_ready),
        .spi_recvdata   (spi_recvdata)
    );

    // 10 ns system clock.
    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    // The bench can force spictl to look busy to test the ISSUE hold.
    assign spi_ready = model_ready && !hold_low;

    // Free-running cycle stamp used to measure spacing between polls.
    always @(posedge sclk) begin
        cyc <= cyc + 1;
    end

    // spictl stand-in: capture each triggered frame, stay busy for a few
    // cycles, and present the next queued status byte for 16-bit frames.
    always @(posedge sclk) begin
        logic [7:0] r;
        if (spi_trig && spi_ready) begin
            if (frame_cnt < 64) begin
                frame_len[frame_cnt]  <= spi_datalength;
                frame_data[frame_cnt] <= spi_senddata;
                frame_cyc[frame_cnt]  <= cyc;
            end
            frame_cnt <= frame_cnt + 1;
            if (spi_datalength == 8'd16) begin
                r = 8'h03;
                if (resp_q.size() > 0) r = resp_q.pop_front();
                spi_recvdata <= {120'h0, r};
            end else begin
                spi_recvdata <= {128{1'b1}};
            end
            model_ready <= 1'b0;
            busy_left   <= 3;
        end else if (busy_left > 0) begin
            if (busy_left == 1) model_ready <= 1'b1;
            busy_left <= busy_left - 1;
        end
    end

    // Count trig and done samples away from the active edge.
    always @(negedge sclk) begin
        if (spi_trig) trig_cnt <= trig_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    // One comparison: counts it, and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle start request with the given op/addr.
    task automatic applyStimulus(input logic [1:0] op_v, input logic [23:0] addr_v);
        @(posedge sclk);
        #1;
        start = 1'b1;
        op    = op_v;
        addr  = addr_v;
        @(posedge sclk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for busy to drop; an expired bound is a failed check.
    task automatic waitNotBusy(input string tag, input int max_cycles);
        logic timed_out;
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge sclk);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        checkOutput(tag, {127'h0, timed_out}, 128'h0);
    endtask

    // Directed test sequence.
    initial begin
        int fb;
        int db;
        int tb;
        int polls;
        logic timed_out;

        n_assert    = 0;
        n_fail      = 0;
        cyc         = 0;
        trig_cnt    = 0;
        done_cnt    = 0;
        frame_cnt   = 0;
        busy_left   = 0;
        model_ready = 1'b1;
        hold_low    = 1'b0;
        spi_recvdata = 128'h0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        addr  = 24'h0;

        // Reset state.
        repeat (3) @(negedge sclk);
        checkOutput("rst_busy",  {127'h0, busy},     128'h0);
        checkOutput("rst_done",  {127'h0, done},     128'h0);
        checkOutput("rst_error", {127'h0, error},    128'h0);
        checkOutput("rst_trig",  {127'h0, spi_trig}, 128'h0);
        checkOutput("rst_status", {120'h0, status},  128'h0);
        checkOutput("rst_len",   {120'h0, spi_datalength}, 128'h0);
        checkOutput("rst_data",  spi_senddata,       128'h0);
        @(posedge sclk);
        #1;
        rst = 1'b0;

        // Chip erase, WIP clears on the third poll.
        resp_q.push_back(8'h03);
        resp_q.push_back(8'h03);
        resp_q.push_back(8'h00);
        fb = frame_cnt;
        db = done_cnt;
        applyStimulus(2'd0, 24'h123456);
        @(negedge sclk);
        checkOutput("chip_first_trig", {127'h0, spi_trig}, 128'h1);
        waitNotBusy("chip_timeout", 500);
        checkOutput("chip_frames", 128'(frame_cnt - fb), 128'd5);
        checkOutput("chip_wren_len", {120'h0, frame_len[fb]}, 128'd8);
        checkOutput("chip_wren_data", frame_data[fb], 128'h06);
        checkOutput("chip_erase_len", {120'h0, frame_len[fb+1]}, 128'd8);
        checkOutput("chip_erase_data", frame_data[fb+1], 128'hC7);
        for (int i = 2; i < 5; i++) begin
            checkOutput("chip_poll_len", {120'h0, frame_len[fb+i]}, 128'd16);
            checkOutput("chip_poll_data", frame_data[fb+i], 128'h0500);
        end
        checkOutput("chip_poll_gap1", {127'h0, (frame_cyc[fb+3] - frame_cyc[fb+2]) >= POLL_GAP}, 128'h1);
        checkOutput("chip_poll_gap2", {127'h0, (frame_cyc[fb+4] - frame_cyc[fb+3]) >= POLL_GAP}, 128'h1);
        checkOutput("chip_done_pulses", 128'(done_cnt - db), 128'd1);
        checkOutput("chip_status", {120'h0, status}, 128'h00);
        checkOutput("chip_error", {127'h0, error}, 128'h0);

        // Sector erase, first poll already idle.
        resp_q.push_back(8'h00);
        fb = frame_cnt;
        db = done_cnt;
        applyStimulus(2'd1, 24'h012000);
        waitNotBusy("sector_timeout", 500);
        checkOutput("sector_frames", 128'(frame_cnt - fb), 128'd3);
        checkOutput("sector_erase_len", {120'h0, frame_len[fb+1]}, 128'd32);
        checkOutput("sector_erase_data", frame_data[fb+1], 128'h20012000);
        checkOutput("sector_done_pulses", 128'(done_cnt - db), 128'd1);

        // Block erase that never clears WIP: timeout after POLL_MAX polls.
        fb = frame_cnt;
        db = done_cnt;
        applyStimulus(2'd2, 24'hABCDEF);
        waitNotBusy("block_timeout", 1000);
        checkOutput("block_erase_len", {120'h0, frame_len[fb+1]}, 128'd32);
        checkOutput("block_erase_data", frame_data[fb+1], 128'hD8ABCDEF);
        polls = 0;
        for (int i = fb; i < frame_cnt; i++) begin
            if (frame_len[i] == 8'd16) polls++;
        end
        checkOutput("block_polls", 128'(polls), 128'd4);
        checkOutput("block_error", {127'h0, error}, 128'h1);
        checkOutput("block_busy", {127'h0, busy}, 128'h0);
        checkOutput("block_status", {120'h0, status}, 128'h03);
        checkOutput("block_done_pulses", 128'(done_cnt - db), 128'd0);

        // Invalid op: no trig, error almost at once; a valid start clears it.
        fb = frame_cnt;
        tb = trig_cnt;
        applyStimulus(2'd3, 24'h0);
        @(negedge sclk);
        checkOutput("bad_error", {127'h0, error}, 128'h1);
        waitNotBusy("bad_timeout", 4);
        checkOutput("bad_trigs", 128'(trig_cnt - tb), 128'd0);
        checkOutput("bad_frames", 128'(frame_cnt - fb), 128'd0);
        resp_q.push_back(8'h00);
        applyStimulus(2'd0, 24'h0);
        @(negedge sclk);
        checkOutput("bad_clear_error", {127'h0, error}, 128'h0);
        waitNotBusy("bad_recover_timeout", 500);

        // spictl busy at start: ISSUE holds, a second start is ignored.
        resp_q.push_back(8'h00);
        hold_low = 1'b1;
        fb = frame_cnt;
        db = done_cnt;
        tb = trig_cnt;
        applyStimulus(2'd0, 24'h0);
        repeat (100) @(negedge sclk);
        checkOutput("hold_no_trig", 128'(trig_cnt - tb), 128'd0);
        checkOutput("hold_busy", {127'h0, busy}, 128'h1);
        applyStimulus(2'd3, 24'h0);
        @(negedge sclk);
        checkOutput("hold_ignore_start", {127'h0, error}, 128'h0);
        @(posedge sclk);
        #1;
        hold_low = 1'b0;
        @(negedge sclk);
        checkOutput("hold_trig_high", {127'h0, spi_trig}, 128'h1);
        @(negedge sclk);
        checkOutput("hold_trig_low", {127'h0, spi_trig}, 128'h0);
        waitNotBusy("hold_timeout", 500);
        checkOutput("hold_frames", 128'(frame_cnt - fb), 128'd3);
        checkOutput("hold_done_pulses", 128'(done_cnt - db), 128'd1);

        // Reset while the erase frame is in flight.
        fb = frame_cnt;
        applyStimulus(2'd1, 24'h0FF000);
        timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge sclk);
            if (frame_cnt == fb + 2) begin
                timed_out = 1'b0;
                break;
            end
        end
        checkOutput("mid_reach_erase", {127'h0, timed_out}, 128'h0);
        rst = 1'b1;
        #1;
        checkOutput("mid_busy",  {127'h0, busy},     128'h0);
        checkOutput("mid_done",  {127'h0, done},     128'h0);
        checkOutput("mid_trig",  {127'h0, spi_trig}, 128'h0);
        checkOutput("mid_len",   {120'h0, spi_datalength}, 128'h0);
        checkOutput("mid_data",  spi_senddata,       128'h0);
        checkOutput("mid_status", {120'h0, status},  128'h0);
        @(posedge sclk);
        #1;
        rst = 1'b0;
        tb = trig_cnt;
        repeat (50) @(negedge sclk);
        checkOutput("mid_no_trig", 128'(trig_cnt - tb), 128'd0);
        checkOutput("mid_frames", 128'(frame_cnt - fb), 128'd2);
        checkOutput("mid_idle", {127'h0, busy}, 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
